pc_sequencer: RTL

- Owns the architectural PC for the 16-bit core and sequences instruction fetch against a multi-cycle instruction memory using a req/ready handshake.
- Resolves branches issued from decode: evaluates condition codes against the Z/V/N flags, computes PC-relative or register targets, redirects fetch, and flushes the wrong-path instruction.
- Handles stall from the hazard unit, HLT, and a fetch watchdog.
- Sits between the imem port and the IF/ID pipeline register.

---
 rtl/pc_sequencer_if.sv | 9 +
 rtl/pc_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction memory request/ready port bundle
interface pc_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC owner, fetch sequencer, branch resolver, halt and fetch watchdog
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MAX_WAIT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  br_valid,
  input  logic                  br_reg_sel,
  input  logic [2:0]            br_cond,
  input  logic [8:0]            br_imm,
  input  logic [15:0]           br_reg_val,
  input  logic [15:0]           br_pc,
  input  logic [2:0]            flags,
  input  logic                  halt_dec,
  pc_sequencer_if.master        imem,
  output logic                  fetch_valid,
  output logic [15:0]           fetch_pc,
  output logic                  flush,
  output logic                  halted,
  output logic                  fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  // Watchdog fires on the waiting cycle that would bring the count to MAX_WAIT.
  localparam logic [7:0] WD_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        discard_q, discard_d;
  logic        halt_pend_q, halt_pend_d;
  logic        fetch_err_q, fetch_err_d;

  logic        cond_true;
  logic        taken;
  logic        in_fetch;
  logic        wd_fire;
  logic [15:0] target;

  // Condition code evaluation against {Z,V,N} and branch target selection.
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000: cond_true = ~flags[2];
      3'b001: cond_true = flags[2];
      3'b010: cond_true = ~flags[2] & ~flags[0];
      3'b011: cond_true = flags[0];
      3'b100: cond_true = flags[2] | ~flags[0];
      3'b101: cond_true = flags[2] | flags[0];
      3'b110: cond_true = flags[1];
      default: cond_true = 1'b1;
    endcase
    taken  = br_valid & cond_true;
    target = br_reg_sel ? (br_reg_val & 16'hFFFE)
                        : (br_pc + 16'd2 + {{6{br_imm[8]}}, br_imm, 1'b0});
  end

  // Next-state logic: watchdog > redirect > halt > stall > advance.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    wait_cnt_d  = wait_cnt_q;
    discard_d   = discard_q;
    halt_pend_d = halt_pend_q;
    fetch_err_d = fetch_err_q;

    in_fetch    = (state_q == S_FETCH);
    wd_fire     = in_fetch & ~imem.imem_ready & (wait_cnt_q == WD_LAST);
    flush       = in_fetch & taken & ~wd_fire;
    fetch_valid = in_fetch & imem.imem_ready & ~stall & ~discard_q & ~halt_pend_q & ~taken;
    fetch_pc    = fetch_valid ? pc_q : 16'h0000;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        addr_d  = pc_q;
      end
      S_FETCH: begin
        wait_cnt_d = imem.imem_ready ? 8'd0 : wait_cnt_q + 8'd1;
        if (wd_fire) begin
          state_d     = S_HALT;
          fetch_err_d = 1'b1;
        end else begin
          if (taken) begin
            // Redirect; an unanswered request still has to finish, its data is thrown away.
            pc_d      = target;
            discard_d = ~imem.imem_ready;
          end else begin
            if (imem.imem_ready) discard_d = 1'b0;
            if (halt_pend_q) begin
              if (imem.imem_ready) state_d = S_HALT;
            end else if (halt_dec && !stall) begin
              if (imem.imem_ready) state_d = S_HALT;
              else                 halt_pend_d = 1'b1;
            end
            if (fetch_valid) pc_d = pc_q + 16'd2;
          end
          // The address only moves once the current transaction completes.
          if (imem.imem_ready) addr_d = pc_d;
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      wait_cnt_q  <= 8'd0;
      discard_q   <= 1'b0;
      halt_pend_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      wait_cnt_q  <= wait_cnt_d;
      discard_q   <= discard_d;
      halt_pend_q <= halt_pend_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = addr_q;
  assign halted         = (state_q == S_HALT);
  assign fetch_err      = fetch_err_q;

endmodule
